// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC and buffers up to DEPTH {pc, instr} pairs for decode.
// Define FETCH_QUEUE_BYPASS_EN to present the memory word combinationally when the queue is empty.
`timescale 1ns/1ps
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic [31:0]                  imem_addr,
  input  logic [31:0]                  imem_rdata,
  input  logic                         stall_d,
  output logic                         valid_d,
  output logic [31:0]                  instr_d,
  output logic [31:0]                  pc_d,
  output logic [31:0]                  pc_plus4_d,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;

  logic          buf_valid;
  logic          full;
  logic          pop;
  logic          push;
  logic          wr_en;
  logic          byp;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    buf_valid = (count_q != '0);
    full      = (count_q == FULL_CNT);
    pop       = buf_valid & ~stall_d & ~redirect_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp       = ~buf_valid & ~redirect_valid & rst;
`else
    byp       = 1'b0;
`endif
    push      = ~redirect_valid & (~full | pop);
    // A bypassed word that decode takes directly advances the PC but never enters the buffer.
    wr_en     = push & ~(byp & ~stall_d);
  end

  always_comb begin
    rptr_d     = rptr_q + PW'(pop);
    wptr_d     = wptr_q + PW'(wr_en);
    count_d    = count_q;
    fetch_pc_d = push ? fetch_pc_q + 32'd4 : fetch_pc_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (redirect_valid) begin
      rptr_d     = '0;
      wptr_d     = '0;
      count_d    = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem_q[wptr_q]    <= fetch_pc_q;
      instr_mem_q[wptr_q] <= imem_rdata;
    end
  end

  always_comb begin
    valid_d    = 1'b0;
    instr_d    = NOP;
    pc_d       = '0;
    pc_plus4_d = '0;
    if (byp) begin
      valid_d    = 1'b1;
      instr_d    = imem_rdata;
      pc_d       = fetch_pc_q;
      pc_plus4_d = fetch_pc_q + 32'd4;
    end else if (buf_valid && !redirect_valid) begin
      valid_d    = 1'b1;
      instr_d    = instr_mem_q[rptr_q];
      pc_d       = pc_mem_q[rptr_q];
      pc_plus4_d = pc_mem_q[rptr_q] + 32'd4;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-of-PCs reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall_d(stall_d), .valid_d(valid_d), .instr_d(instr_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch PC plus a queue of buffered PCs (instr is always mem(pc)).
  logic [31:0] mq[$];
  logic [31:0] mpc;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    int  n;
    bit  popped;
    if (!rst) begin
      mq.delete();
      mpc      = RESET_PC;
      model_on = 1'b1;
    end else if (model_on) begin
      if (redirect_valid) begin
        mq.delete();
        mpc = redirect_pc & ~32'h3;
      end else begin
        n      = mq.size();
        popped = (n > 0) && !stall_d;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (n == 0) begin
          if (stall_d) mq.push_back(mpc);
          mpc = mpc + 32'd4;
        end else
`endif
        begin
          if (popped) void'(mq.pop_front());
          if (n < DEPTH || popped) begin
            mq.push_back(mpc);
            mpc = mpc + 32'd4;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic        e_valid;
    logic [31:0] e_pc, e_instr, e_p4;
    if (model_on) begin
      e_valid = 1'b0;
      e_pc    = 32'h0;
      e_instr = 32'h0000_0013;
      if (!redirect_valid && mq.size() > 0) begin
        e_valid = 1'b1;
        e_pc    = mq[0];
        e_instr = mem(mq[0]);
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      if (!redirect_valid && mq.size() == 0 && rst) begin
        e_valid = 1'b1;
        e_pc    = mpc;
        e_instr = mem(mpc);
      end
`endif
      e_p4 = e_valid ? e_pc + 32'd4 : 32'h0;
      chk("model_valid_d", 32'(valid_d), 32'(e_valid));
      chk("model_pc_d", pc_d, e_pc);
      chk("model_instr_d", instr_d, e_instr);
      chk("model_pc_plus4_d", pc_plus4_d, e_p4);
      chk("model_count", 32'(count), 32'(mq.size()));
      chk("model_imem_addr", imem_addr, mpc);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] spat;
    spat = 40'hC3_5A_0F_96_E1;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; stall_d = 1'b0;
    nxt(); nxt();
    @(negedge clk); #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_valid", 32'(valid_d), 32'h0);
    chk("rst_instr", instr_d, 32'h0000_0013);
    chk("rst_pc", pc_d, 32'h0);
    chk("rst_pc4", pc_plus4_d, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);

    // Stream from reset
    rst = 1'b1;
    repeat (LAT) nxt();
    #1;
    chk("stream_valid0", 32'(valid_d), 32'h1);
    chk("stream_pc0", pc_d, 32'h0);
    chk("stream_instr0", instr_d, 32'h5A5A_0013);
    nxt(); #1;
    chk("stream_pc4", pc_d, 32'h4);
    nxt(); #1;
    chk("stream_pc8", pc_d, 32'h8);
    chk("stream_pc8_plus4", pc_plus4_d, 32'hC);
    nxt(); nxt();

    // Reset, then fill to full under stall
    rst = 1'b0;
    nxt();
    rst = 1'b1; stall_d = 1'b1;
    repeat (8) nxt();
    @(negedge clk); #1;
    chk("fill_count", 32'(count), 32'h4);
    chk("fill_imem_addr", imem_addr, 32'h10);
    chk("fill_pc", pc_d, 32'h0);
    chk("fill_valid", 32'(valid_d), 32'h1);

    // Push and pop together while full
    stall_d = 1'b0;
    nxt(); #1;
    chk("pp_count1", 32'(count), 32'h4);
    chk("pp_pc1", pc_d, 32'h4);
    nxt(); #1;
    chk("pp_count2", 32'(count), 32'h4);
    chk("pp_pc2", pc_d, 32'h8);
    nxt();
    stall_d = 1'b1; #1;
    chk("pp_count3", 32'(count), 32'h4);
    chk("pp_pc3", pc_d, 32'hC);
    chk("pp_imem_addr", imem_addr, 32'h1C);

    // Redirect while full and stalled
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    chk("redir_valid_forced", 32'(valid_d), 32'h0);
    nxt();
    redirect_valid = 1'b0; #1;
    chk("redir_count", 32'(count), 32'h0);
    chk("redir_imem_addr", imem_addr, 32'h100);
    stall_d = 1'b0;
    repeat (LAT) nxt();
    #1;
    chk("redir_target_valid", 32'(valid_d), 32'h1);
    chk("redir_target_pc", pc_d, 32'h100);
    nxt(); nxt(); nxt();

    // Build count=3, then reset mid-operation
    redirect_valid = 1'b1; redirect_pc = 32'h200; stall_d = 1'b1;
    nxt();
    redirect_valid = 1'b0;
    nxt(); nxt(); nxt(); #1;
    chk("mid_count3", 32'(count), 32'h3);
    rst = 1'b0;
    nxt(); #1;
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_valid", 32'(valid_d), 32'h0);
    chk("mid_rst_imem_addr", imem_addr, RESET_PC);
    rst = 1'b1;
    nxt();

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    nxt();
    redirect_valid = 1'b0;
    nxt(); nxt(); #1;
    chk("wrap_pc", pc_d, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_d, 32'h0);
    chk("wrap_count", 32'(count), 32'h2);
    stall_d = 1'b0;
    nxt(); #1;
    chk("wrap_next_pc", pc_d, 32'h0);
    chk("wrap_next_pc4", pc_plus4_d, 32'h4);

    // Mixed stall pattern with a redirect in the middle
    for (int i = 0; i < 40; i++) begin
      stall_d        = spat[i];
      redirect_valid = (i == 20) || (i == 33);
      redirect_pc    = (i == 20) ? 32'h0000_0042 : 32'h0000_0800;
      nxt();
    end
    redirect_valid = 1'b0; stall_d = 1'b0;
    nxt(); nxt();
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
